// File: rtl/des_pkg.sv
// Shared DES key-schedule tables and constants: PC1/PC2 selections and per-round shift amounts.
package des_pkg;

    localparam int DES_ROUNDS   = 16;
    localparam int DES_KEY_W    = 64;
    localparam int DES_CD_W     = 28;
    localparam int DES_SUBKEY_W = 48;
    localparam int DES_SALT_W   = 12;

    // Entries are DES bit numbers (1 = MSB of the source word), listed in output order.
    localparam logic [5:0] PC1_TAB [0:55] = '{
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
        6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
        6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
        6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
        6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
        6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
        6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
        6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
    };

    localparam logic [5:0] PC2_TAB [0:47] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    // Shifts sum to 28, so a full pass returns C,D to the loaded value.
    localparam logic [1:0] SHIFT_TAB [0:15] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } kg_state_e;

    function automatic logic [27:0] rotl_cd(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd1:    rotl_cd = {x[26:0], x[27]};
            2'd2:    rotl_cd = {x[25:0], x[27:26]};
            default: rotl_cd = x;
        endcase
    endfunction

endpackage

// File: rtl/des_pc2.sv
// PC2 compression: 56-bit {C,D} to 48-bit round subkey, pure wiring.
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd_i,
    output logic [47:0] subkey_o
);

    for (genvar i = 0; i < DES_SUBKEY_W; i++) begin : g_bit
        localparam int SRC = 56 - int'(PC2_TAB[i]);
        assign subkey_o[47 - i] = cd_i[SRC];
    end

endmodule

// File: rtl/des_round_key_gen.sv
// Salted DES round-key source: one {salt, subkey} word per handshake, 16 x ITERATIONS per load.
// Build option DES_KEYGEN_OUTREG_EN registers K_OUT/ROUND/ITER/LAST in a one-entry output stage.
module des_round_key_gen
    import des_pkg::*;
#(
    parameter int ITERATIONS = 25
)
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [63:0] KEY_IN,
    input  logic [11:0] SALT_IN,
    input  logic        LOAD_VALID,
    output logic        LOAD_READY,
    output logic [59:0] K_OUT,
    output logic        K_VALID,
    input  logic        K_READY,
    output logic [3:0]  ROUND,
    output logic [4:0]  ITER,
    output logic        LAST,
    output logic        DONE
);

    localparam logic [4:0] LAST_ITER = 5'(ITERATIONS - 1);

    kg_state_e   state_q, state_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [11:0] salt_q, salt_d;
    logic [3:0]  round_q, round_d;
    logic [4:0]  iter_q, iter_d;
    logic        done_q, done_d;

    logic [55:0] pc1_s;
    logic [47:0] subkey_s;
    logic [1:0]  shift_s;
    logic        src_valid_s, src_ready_s, src_last_s, src_fire_s;
    logic [59:0] src_k_s;
    logic        k_valid_s, k_last_s, load_ready_s;
    logic        unused_parity_s;

    for (genvar j = 0; j < 56; j++) begin : g_pc1
        localparam int SRC = DES_KEY_W - int'(PC1_TAB[j]);
        assign pc1_s[55 - j] = KEY_IN[SRC];
    end

    assign unused_parity_s = ^{KEY_IN[56], KEY_IN[48], KEY_IN[40], KEY_IN[32],
                               KEY_IN[24], KEY_IN[16], KEY_IN[8],  KEY_IN[0]};

    des_pc2 u_pc2 (
        .cd_i     ({c_q, d_q}),
        .subkey_o (subkey_s)
    );

    assign src_valid_s = (state_q == ST_RUN);
    assign src_last_s  = src_valid_s && (round_q == 4'd15) && (iter_q == LAST_ITER);
    assign src_k_s     = src_valid_s ? {salt_q, subkey_s} : 60'd0;
    assign src_fire_s  = src_valid_s && src_ready_s;
    assign shift_s     = SHIFT_TAB[round_q + 4'd1];

    // Next-state for the load/run sequencer, key halves and round/iteration counters.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        salt_d  = salt_q;
        round_d = round_q;
        iter_d  = iter_q;
        case (state_q)
            ST_IDLE: begin
                if (LOAD_VALID && load_ready_s) begin
                    c_d     = rotl_cd(pc1_s[55:28], SHIFT_TAB[0]);
                    d_d     = rotl_cd(pc1_s[27:0], SHIFT_TAB[0]);
                    salt_d  = SALT_IN;
                    round_d = 4'd0;
                    iter_d  = 5'd0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (src_fire_s) begin
                    round_d = round_q + 4'd1;
                    c_d     = rotl_cd(c_q, shift_s);
                    d_d     = rotl_cd(d_q, shift_s);
                    if (src_last_s) begin
                        iter_d  = 5'd0;
                        state_d = ST_IDLE;
                    end else if (round_q == 4'd15) begin
                        iter_d = iter_q + 5'd1;
                    end else begin
                        iter_d = iter_q;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign done_d = k_valid_s && K_READY && k_last_s;

    // Sequencer, key-schedule and DONE registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            c_q     <= 28'd0;
            d_q     <= 28'd0;
            salt_q  <= 12'd0;
            round_q <= 4'd0;
            iter_q  <= 5'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            salt_q  <= salt_d;
            round_q <= round_d;
            iter_q  <= iter_d;
            done_q  <= done_d;
        end
    end

`ifdef DES_KEYGEN_OUTREG_EN
    logic        ovalid_q, ovalid_d;
    logic [59:0] ok_q, ok_d;
    logic [3:0]  oround_q, oround_d;
    logic [4:0]  oiter_q, oiter_d;
    logic        olast_q, olast_d;

    // Output stage refills whenever it is empty or being drained, keeping full throughput.
    assign src_ready_s = !ovalid_q || K_READY;

    // Output stage next-state: capture the source word when the stage can accept it.
    always_comb begin
        ovalid_d = ovalid_q;
        ok_d     = ok_q;
        oround_d = oround_q;
        oiter_d  = oiter_q;
        olast_d  = olast_q;
        if (src_ready_s) begin
            ovalid_d = src_valid_s;
            ok_d     = src_k_s;
            oround_d = round_q;
            oiter_d  = iter_q;
            olast_d  = src_last_s;
        end else begin
            ovalid_d = ovalid_q;
        end
    end

    // Output stage registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovalid_q <= 1'b0;
            ok_q     <= 60'd0;
            oround_q <= 4'd0;
            oiter_q  <= 5'd0;
            olast_q  <= 1'b0;
        end else begin
            ovalid_q <= ovalid_d;
            ok_q     <= ok_d;
            oround_q <= oround_d;
            oiter_q  <= oiter_d;
            olast_q  <= olast_d;
        end
    end

    assign k_valid_s    = ovalid_q;
    assign k_last_s     = olast_q;
    assign load_ready_s = (state_q == ST_IDLE) && !ovalid_q;
    assign K_OUT        = ok_q;
    assign ROUND        = oround_q;
    assign ITER         = oiter_q;
`else
    assign src_ready_s  = K_READY;
    assign k_valid_s    = src_valid_s;
    assign k_last_s     = src_last_s;
    assign load_ready_s = (state_q == ST_IDLE);
    assign K_OUT        = src_k_s;
    assign ROUND        = round_q;
    assign ITER         = iter_q;
`endif

    assign K_VALID    = k_valid_s;
    assign LAST       = k_last_s;
    assign LOAD_READY = load_ready_s;
    assign DONE       = done_q;

endmodule

// File: tb/tb_des_round_key_gen.sv
// Self-checking bench for des_round_key_gen: known-answer table, reference-model streams,
// stalls, back-to-back loads and mid-stream reset.
module tb_des_round_key_gen;

    localparam int ITERS = 25;
    localparam int TOTAL = 16 * ITERS;
    localparam logic [63:0] KNOWN_KEY = 64'h133457799BBCDFF1;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [63:0] KEY_IN = 64'd0;
    logic [11:0] SALT_IN = 12'd0;
    logic        LOAD_VALID = 1'b0;
    logic        LOAD_READY;
    logic [59:0] K_OUT;
    logic        K_VALID;
    logic        K_READY = 1'b0;
    logic [3:0]  ROUND;
    logic [4:0]  ITER;
    logic        LAST;
    logic        DONE;

    int n_checks = 0;
    int n_fail   = 0;

    des_round_key_gen #(.ITERATIONS(ITERS)) dut (
        .CLK(CLK), .RST(RST), .KEY_IN(KEY_IN), .SALT_IN(SALT_IN),
        .LOAD_VALID(LOAD_VALID), .LOAD_READY(LOAD_READY),
        .K_OUT(K_OUT), .K_VALID(K_VALID), .K_READY(K_READY),
        .ROUND(ROUND), .ITER(ITER), .LAST(LAST), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // Reference key schedule written from the DES tables by bit number.
    int PC1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                     19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                     14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    int PC2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                     41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    int SH [16]  = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    function automatic logic [47:0] model_subkey(input logic [63:0] key, input int r);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [63:0] t;
        logic [55:0] t2;
        logic [47:0] k;
        int cum;
        cum = 0;
        for (int i = 0; i <= r; i++) cum += SH[i];
        cum = cum % 28;
        cd = 56'd0;
        for (int j = 0; j < 56; j++) begin
            t  = key >> (64 - PC1[j]);
            cd = {cd[54:0], t[0]};
        end
        c  = cd[55:28];
        d  = cd[27:0];
        c  = (c << cum) | (c >> (28 - cum));
        d  = (d << cum) | (d >> (28 - cum));
        cd = {c, d};
        k  = 48'd0;
        for (int j = 0; j < 48; j++) begin
            t2 = cd >> (56 - PC2[j]);
            k  = {k[46:0], t2[0]};
        end
        return k;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " k_valid"},    64'(K_VALID),    64'd0);
        check({tag, " k_out"},      64'(K_OUT),      64'd0);
        check({tag, " round"},      64'(ROUND),      64'd0);
        check({tag, " iter"},       64'(ITER),       64'd0);
        check({tag, " done"},       64'(DONE),       64'd0);
        check({tag, " last"},       64'(LAST),       64'd0);
        check({tag, " load_ready"}, 64'(LOAD_READY), 64'd1);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        LOAD_VALID = 1'b0;
        K_READY = 1'b0;
        step();
        step();
        RST = 1'b0;
        step();
    endtask

    task automatic load_key(input logic [63:0] key, input logic [11:0] salt);
        int waits;
        KEY_IN = key;
        SALT_IN = salt;
        LOAD_VALID = 1'b1;
        waits = 0;
        while (!LOAD_READY && waits < 50) begin
            step();
            waits++;
        end
        if (waits >= 50) check("load_ready timeout", 64'(LOAD_READY), 64'd1);
        step();
        LOAD_VALID = 1'b0;
        check("load latency k_valid", 64'(K_VALID), 64'd1);
    endtask

    // Drives one loaded stream to completion (or to a reset at accept index abort_at).
    task automatic run_stream(input logic [63:0] key, input logic [11:0] salt, input bit rand_ready,
                              input bit hold_next, input logic [63:0] nkey, input int abort_at);
        logic [47:0] exp_sub [16];
        int idx, cyc;
        bit aborted;
        for (int r = 0; r < 16; r++) exp_sub[r] = model_subkey(key, r);
        if (hold_next) begin
            LOAD_VALID = 1'b1;
            KEY_IN = nkey;
            SALT_IN = ~salt;
        end
        idx = 0;
        cyc = 0;
        aborted = 1'b0;
        while (idx < TOTAL && cyc < 4000 && !aborted) begin
            K_READY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            check("stream k_valid", 64'(K_VALID), 64'd1);
            check("stream k_out", 64'(K_OUT), 64'({salt, exp_sub[idx % 16]}));
            check("stream round", 64'(ROUND), 64'(idx % 16));
            check("stream iter", 64'(ITER), 64'(idx / 16));
            check("stream last", 64'(LAST), 64'(idx == TOTAL - 1));
            check("stream load_ready", 64'(LOAD_READY), 64'd0);
            check("stream done", 64'(DONE), 64'd0);
            if (idx == abort_at) begin
                RST = 1'b1;
                #1;
                check_reset_values("midstream reset");
                step();
                RST = 1'b0;
                K_READY = 1'b1;
                aborted = 1'b1;
            end else begin
                if (K_READY) idx++;
                step();
                cyc++;
            end
        end
        if (aborted) begin
            for (int i = 0; i < 3; i++) begin
                check("post-reset done", 64'(DONE), 64'd0);
                check("post-reset k_valid", 64'(K_VALID), 64'd0);
                step();
            end
        end else if (idx < TOTAL) begin
            check("stream accept timeout", 64'(idx), 64'(TOTAL));
        end else begin
            check("done after last", 64'(DONE), 64'd1);
            check("k_valid after last", 64'(K_VALID), 64'd0);
            check("load_ready with done", 64'(LOAD_READY), 64'd1);
            K_READY = 1'b0;
            if (!hold_next) begin
                step();
                check("done one cycle", 64'(DONE), 64'd0);
            end
        end
    endtask

    typedef struct {
        logic [63:0] key;
        logic [11:0] salt;
        int          idx;
        logic [59:0] exp_k;
        logic [3:0]  exp_round;
        logic [4:0]  exp_iter;
        logic        exp_last;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [63:0] k1, k2, k3;
        logic [11:0] s1;

        vecs[0] = '{KNOWN_KEY, 12'h000, 0,   {12'h000, 48'h1B02EFFC7072}, 4'd0,  5'd0,  1'b0};
        vecs[1] = '{KNOWN_KEY, 12'h000, 15,  {12'h000, 48'hCB3D8B0E17F5}, 4'd15, 5'd0,  1'b0};
        vecs[2] = '{KNOWN_KEY, 12'h000, 16,  {12'h000, 48'h1B02EFFC7072}, 4'd0,  5'd1,  1'b0};
        vecs[3] = '{KNOWN_KEY, 12'h000, 399, {12'h000, 48'hCB3D8B0E17F5}, 4'd15, 5'd24, 1'b1};
        vecs[4] = '{KNOWN_KEY, 12'hA5C, 0,   {12'hA5C, 48'h1B02EFFC7072}, 4'd0,  5'd0,  1'b0};
        vecs[5] = '{KNOWN_KEY, 12'hA5C, 31,  {12'hA5C, 48'hCB3D8B0E17F5}, 4'd15, 5'd1,  1'b0};

        do_reset();
        check_reset_values("reset");

        // Known-answer table: advance to the listed accept index, then compare.
        for (int v = 0; v < 6; v++) begin
            load_key(vecs[v].key, vecs[v].salt);
            K_READY = 1'b1;
            for (int i = 0; i < vecs[v].idx; i++) step();
            K_READY = 1'b0;
            check("vec k_out", 64'(K_OUT), 64'(vecs[v].exp_k));
            check("vec round", 64'(ROUND), 64'(vecs[v].exp_round));
            check("vec iter", 64'(ITER), 64'(vecs[v].exp_iter));
            check("vec last", 64'(LAST), 64'(vecs[v].exp_last));
            do_reset();
        end

        // Full streams: known key, then salted, then random key with random stalls.
        load_key(KNOWN_KEY, 12'h000);
        run_stream(KNOWN_KEY, 12'h000, 1'b0, 1'b0, 64'd0, -1);
        load_key(KNOWN_KEY, 12'hA5C);
        run_stream(KNOWN_KEY, 12'hA5C, 1'b0, 1'b0, 64'd0, -1);
        k1 = {$urandom, $urandom};
        s1 = 12'($urandom);
        load_key(k1, s1);
        run_stream(k1, s1, 1'b1, 1'b0, 64'd0, -1);

        // LOAD_VALID held through a stream; the pending load is taken in the DONE cycle.
        k2 = {$urandom, $urandom};
        k3 = {$urandom, $urandom};
        load_key(k2, 12'h3C1);
        run_stream(k2, 12'h3C1, 1'b1, 1'b1, k3, -1);
        load_key(k3, ~12'h3C1);
        run_stream(k3, ~12'h3C1, 1'b0, 1'b0, 64'd0, -1);

        // Reset at ROUND=7 ITER=3, then a clean reload.
        load_key(k1, s1);
        run_stream(k1, s1, 1'b0, 1'b0, 64'd0, 55);
        check_reset_values("after abort");
        load_key(KNOWN_KEY, 12'h5A5);
        run_stream(KNOWN_KEY, 12'h5A5, 1'b1, 1'b0, 64'd0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
